// File: rtl/sm_input_conditioner_if.sv
// Handshake bundle between the raw input lines and the conditioned outputs.
interface sm_input_conditioner_if #(
    parameter int N_IN = 3
);
    logic [N_IN-1:0] raw_in;
    logic [N_IN-1:0] lvl_out;
    logic [N_IN-1:0] pulse_out;
    logic            busy;

    modport master (output raw_in, input lvl_out, pulse_out, busy);
    modport slave  (input raw_in, output lvl_out, pulse_out, busy);
endinterface

// File: rtl/sm_input_conditioner.sv
// Two-flop synchronizer plus per-channel debounce FSM producing a clean level
// and a one-cycle rising-edge pulse for each raw input line.
//
// state     | meaning
// STABLE_LO | accepted level 0, sync agrees
// PEND_HI   | sync went 1, counting persistence before accepting 1
// STABLE_HI | accepted level 1, sync agrees
// PEND_LO   | sync went 0, counting persistence before accepting 0
module sm_input_conditioner #(
    parameter int N_IN       = 3,
    parameter int DEB_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    sm_input_conditioner_if.slave  io
);
    localparam int CW = $clog2(DEB_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {STABLE_LO, PEND_HI, STABLE_HI, PEND_LO} state_t;

    state_t          state_q [N_IN];
    state_t          state_d [N_IN];
    logic [CW-1:0]   cnt_q   [N_IN];
    logic [CW-1:0]   cnt_d   [N_IN];
    logic [N_IN-1:0] s1_q, s1_d, s2_q, s2_d;
    logic [N_IN-1:0] lvl_q, lvl_d, pulse_q, pulse_d;
    logic            busy;

    always_comb begin
        s1_d = io.raw_in;
        s2_d = s1_q;
        for (int i = 0; i < N_IN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                STABLE_LO: if (s2_q[i]) begin
                    if (DEB_CYCLES == 1) begin
                        state_d[i] = STABLE_HI;
                    end else begin
                        state_d[i] = PEND_HI;
                        cnt_d[i]   = CW'(1);
                    end
                end
                PEND_HI: begin
                    if (!s2_q[i]) begin
                        state_d[i] = STABLE_LO;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = STABLE_HI;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
                STABLE_HI: if (!s2_q[i]) begin
                    if (DEB_CYCLES == 1) begin
                        state_d[i] = STABLE_LO;
                    end else begin
                        state_d[i] = PEND_LO;
                        cnt_d[i]   = CW'(1);
                    end
                end
                PEND_LO: begin
                    if (s2_q[i]) begin
                        state_d[i] = STABLE_HI;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = STABLE_LO;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
                default: begin
                    state_d[i] = STABLE_LO;
                    cnt_d[i]   = '0;
                end
            endcase
            // Outputs follow the next state so they change on the accepting edge.
            lvl_d[i]   = (state_d[i] == STABLE_HI) || (state_d[i] == PEND_LO);
            pulse_d[i] = lvl_d[i] & ~lvl_q[i];
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            busy = busy | (state_q[i] == PEND_HI) | (state_q[i] == PEND_LO);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            lvl_q   <= '0;
            pulse_q <= '0;
            for (int i = 0; i < N_IN; i++) begin
                state_q[i] <= STABLE_LO;
                cnt_q[i]   <= '0;
            end
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            lvl_q   <= lvl_d;
            pulse_q <= pulse_d;
            for (int i = 0; i < N_IN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign io.lvl_out   = lvl_q;
    assign io.pulse_out = pulse_q;
    assign io.busy      = busy;
endmodule
